// File: rtl/m68k_bus_pkg.sv
// Shared definitions for 68000 bus responders.
// Holds the responder state encoding and the default ack timeout.
package m68k_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } bus_state_e;

    localparam int unsigned DEF_TIMEOUT = 255;

endpackage

// File: rtl/m68k_bus_responder.sv
// 68000 bus slave: turns CPU strobes into a memory request/ack
// handshake, answering with DTACK, or BERR when memory times out.
// Ports: clk, reset_n; CPU side as_n/uds_n/lds_n/rw/addr/din/sel
// in, dtack_n/berr_n/dout out; memory side mem_req/mem_we/
// mem_addr/mem_wdata/mem_be out, mem_ack/mem_rdata in.
module m68k_bus_responder
    import m68k_bus_pkg::*;
#(
    parameter int C_ADDR_BITS = 23,
    parameter int C_TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   as_n,
    input  logic                   uds_n,
    input  logic                   lds_n,
    input  logic                   rw,
    input  logic [C_ADDR_BITS-1:0] addr,
    input  logic [15:0]            din,
    input  logic                   sel,
    output logic                   dtack_n,
    output logic                   berr_n,
    output logic [15:0]            dout,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [C_ADDR_BITS-1:0] mem_addr,
    output logic [15:0]            mem_wdata,
    output logic [1:0]             mem_be,
    input  logic                   mem_ack,
    input  logic [15:0]            mem_rdata
);

    localparam int CW = $clog2(C_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(C_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(C_TIMEOUT - 1);

    bus_state_e    state_q;
    bus_state_e    state_d;
    logic [CW-1:0] cnt_q;
    logic          abort_q;
    logic          start;
    logic          tmo_hit;
    logic          aborted;

    assign start   = !as_n && sel && (!uds_n || !lds_n);
    // This REQ cycle is the last one the counter allows.
    assign tmo_hit = (cnt_q >= CNT_LAST);
    // CPU dropped AS at any point of the request, this cycle included.
    assign aborted = abort_q || as_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Ack is checked first so it wins over a timeout.
                if (mem_ack) begin
                    state_d = aborted ? ST_IDLE : ST_DONE;
                end else if (tmo_hit) begin
                    state_d = aborted ? ST_IDLE : ST_ERR;
                end
            end
            ST_DONE, ST_ERR: begin
                if (as_n) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req = (state_q == ST_REQ);
        dtack_n = (state_q != ST_DONE);
        berr_n  = (state_q != ST_ERR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_be    <= 2'b00;
            dout      <= '0;
            cnt_q     <= '0;
            abort_q   <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (start) begin
                mem_addr  <= addr;
                mem_wdata <= din;
                mem_we    <= ~rw;
                mem_be    <= {~uds_n, ~lds_n};
                cnt_q     <= '0;
                abort_q   <= 1'b0;
            end
        end else if (state_q == ST_REQ) begin
            if (as_n) begin
                abort_q <= 1'b1;
            end
            if (mem_ack) begin
                if (!mem_we) begin
                    dout <= mem_rdata;
                end
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: doc/m68k_bus_responder.md
M68K_BUS_RESPONDER -- requirements
Module: m68k_bus_responder

Interface
REQ-001 Parameter C_ADDR_BITS, default 23, SHALL set the CPU word-address width (addr[23:1]).
REQ-002 Parameter C_TIMEOUT, default 255, SHALL set the maximum number of clk cycles waiting for mem_ack before a bus error.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock (CPU clock domain).
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 as_n, uds_n, lds_n, rw  in  1 each  68000 bus strobes; rw is 1 for read.
REQ-007 addr  in  C_ADDR_BITS  CPU word address.
REQ-008 din  in  16  CPU write data.
REQ-009 sel  in  1  external address-decode hit for this responder.
REQ-010 dtack_n  out  1  data-transfer acknowledge to the CPU.
REQ-011 berr_n  out  1  bus error to the CPU.
REQ-012 dout  out  16  read data to the CPU.
REQ-013 mem_req  out  1  memory request, a level held until acknowledged.
REQ-014 mem_we  out  1  memory write.
REQ-015 mem_addr  out  C_ADDR_BITS  memory address.
REQ-016 mem_wdata  out  16  memory write data.
REQ-017 mem_be  out  2  byte enables; [1] is the upper byte (UDS), [0] is the lower byte (LDS).
REQ-018 mem_ack  in  1  single-cycle completion pulse from memory.
REQ-019 mem_rdata  in  16  read data, valid in the mem_ack cycle.

Function
REQ-020 All inputs SHALL be sampled on the rising edge of clk, without phase-enable gating.
REQ-021 The FSM SHALL have exactly four states: IDLE, REQ, DONE, ERR.
REQ-022 IDLE->REQ: as_n=0, sel=1, and (uds_n=0 or lds_n=0) are all sampled in the same cycle. Write cycles therefore start only once the data strobes are valid.
REQ-023 On entry to REQ, the block SHALL latch mem_addr=addr, mem_wdata=din, mem_we=~rw, and mem_be={~uds_n,~lds_n}; these SHALL stay stable until the next IDLE->REQ transition.
REQ-024 mem_req SHALL be 1 throughout REQ and 0 in every other state.
REQ-025 Latency: strobes sampled in cycle N -> mem_req=1 in cycle N+1.
REQ-026 mem_ack sampled in cycle M -> REQ->DONE and dtack_n=0 in M+1.
REQ-027 For a zero-wait memory (ack in the first REQ cycle), dtack_n=0 in N+2.
REQ-028 On a read ack, dout SHALL load mem_rdata. On a write ack, dout SHALL hold its previous value.
REQ-029 In DONE, dtack_n SHALL stay 0 until as_n=1 is sampled; then the FSM SHALL go to IDLE with dtack_n=1 in the next cycle.
REQ-030 Timeout counter: cleared on entry to REQ and incremented each REQ cycle without mem_ack. When the count reaches C_TIMEOUT, the FSM SHALL go REQ->ERR.
REQ-031 In ERR, berr_n=0 and mem_req=0 until as_n=1 is sampled, then IDLE.
REQ-032 mem_ack and timeout in the same cycle: ack SHALL win (go to DONE).
REQ-033 Aborted cycle (as_n=1 sampled in REQ): mem_req SHALL stay asserted until mem_ack or timeout, then the FSM SHALL go directly to IDLE with no dtack_n or berr_n pulse.
REQ-034 mem_ack sampled outside REQ SHALL be ignored.
REQ-035 as_n=0 with sel=0, or with both data strobes high, SHALL produce no response (dtack_n=1, berr_n=1).
REQ-036 A back-to-back cycle SHALL require as_n to be sampled 1 for at least one cycle; there SHALL be no re-trigger while as_n stays 0.
REQ-037 The counter width SHALL be clog2(C_TIMEOUT+1), and the counter SHALL saturate, never wrap.

Reset
REQ-038 reset_n=0 SHALL asynchronously force: state=IDLE, dtack_n=1, berr_n=1, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, dout=0, counter=0.
REQ-039 Reset asserted mid-transaction SHALL drop mem_req immediately; a subsequent stale mem_ack SHALL be ignored per REQ-034.

Structure
REQ-040 Package m68k_bus_pkg SHALL hold the state encoding (IDLE=0, REQ=1, DONE=2, ERR=3) and the default timeout constant, so that other bus responders can share them.
REQ-041 The block SHALL be a single module with no sub-modules.

Verification
REQ-042 Read, 3-cycle memory: addr=0x012340, uds_n=lds_n=0, rw=1, ack 3 cycles after req with rdata=0xBEEF -> mem_be=2'b11, mem_we=0, dout=0xBEEF, and dtack_n=0 one cycle after ack until as_n rises.
REQ-043 Byte write: lds_n=0, uds_n=1, din=0x00A5, zero-wait ack -> mem_be=2'b01, mem_we=1, mem_wdata=0x00A5, dtack_n=0 at N+2, and dout unchanged.
REQ-044 Timeout with C_TIMEOUT=8, no ack -> mem_req high for 8 cycles then low, berr_n=0 until as_n=1, and dtack_n stays 1.
REQ-045 Abort: as_n rises 1 cycle after req, ack 4 cycles later -> mem_req held until ack, with no dtack_n or berr_n pulse, and the FSM back in IDLE.
REQ-046 Reset mid-REQ followed by a stray mem_ack -> all outputs return to reset values asynchronously and the ack is ignored.
REQ-047 sel=0 access, then ack and timeout coinciding on a selected access -> no response to the first; dtack_n (not berr_n) asserts for the second.
